// File: rtl/cpu_datapath_pkg.sv
// cpu_datapath_pkg
//    Shared definitions for the accumulator CPU datapath and its controller:
//    opcode encodings, accumulator-source select encodings and a helper that
//    classifies the two unassigned (illegal) opcodes.
package cpu_datapath_pkg;

   // Opcode map (IR[7:4]); 1001 and 1110 are unassigned
   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_NOR  = 4'b0011;
   localparam logic [3:0] OP_MOVR = 4'b0100;   // ACC <= reg[operand]
   localparam logic [3:0] OP_MOVA = 4'b0101;   // reg[operand] <= ACC
   localparam logic [3:0] OP_JZRS = 4'b0110;   // jump if z to reg[operand]
   localparam logic [3:0] OP_JZIM = 4'b0111;   // jump if z to operand
   localparam logic [3:0] OP_JCRS = 4'b1000;   // jump if c to reg[operand]
   localparam logic [3:0] OP_ILL9 = 4'b1001;
   localparam logic [3:0] OP_JCIM = 4'b1010;   // jump if c to operand
   localparam logic [3:0] OP_SHL  = 4'b1011;
   localparam logic [3:0] OP_SHR  = 4'b1100;
   localparam logic [3:0] OP_LDI  = 4'b1101;   // ACC <= operand
   localparam logic [3:0] OP_ILLE = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   // Accumulator source select
   typedef enum logic [1:0] {
      SEL_ACC_ALU = 2'b00,
      SEL_ACC_RSV = 2'b01,
      SEL_ACC_REG = 2'b10,
      SEL_ACC_IMM = 2'b11
   } sel_acc_e;

   // True for the opcodes that have no instruction assigned
   function automatic logic is_illegal_op(input logic [3:0] opc);
      return (opc == OP_ILL9) || (opc == OP_ILLE);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu
//    Combinational ALU of the accumulator CPU. fn uses the opcode encoding.
//    Ports:
//       a, b    in   DATA_W   operands (a = ACC, b = reg[operand])
//       fn      in   4        function select
//       cin     in   1        current carry flag, passed through for non-ALU codes
//       result  out  DATA_W   function result
//       cout    out  1        carry / borrow / shifted-out bit
module cpu_alu
   import cpu_datapath_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        fn,
   input  logic              cin,
   output logic [DATA_W-1:0] result,
   output logic              cout
);

   // ALU function decode
   always_comb begin
      result = a;
      cout   = cin;
      case (fn)
         OP_ADD: {cout, result} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            result = a - b;
            cout   = (a < b);   // borrow
         end
         OP_NOR: begin
            result = ~(a | b);
            cout   = 1'b0;
         end
         OP_SHL: begin
            result = {a[DATA_W-2:0], 1'b0};
            cout   = a[DATA_W-1];
         end
         OP_SHR: begin
            result = {1'b0, a[DATA_W-1:1]};
            cout   = a[0];
         end
         default: begin
            result = a;
            cout   = cin;
         end
      endcase
   end

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath
//    Datapath of the 4-bit-opcode accumulator CPU. Executes the controller
//    strobes: holds PC, IR, ACC, a 16-entry register file and the z/c flags,
//    and contains the ALU. All outputs come straight from registers.
//    Ports:
//       clk         in   1        rising-edge clock
//       CLB         in   1        asynchronous active-low reset
//       imem_data   in   8        instruction at imem_addr ([7:4] op, [3:0] operand)
//       LoadIR      in   1        IR <= imem_data
//       IncPC       in   1        PC <= PC + 1
//       SelPC       in   1        jump target: 1 = reg[operand], 0 = operand
//       LoadPC      in   1        conditional jump strobe
//       LoadReg     in   1        reg[operand] <= ACC
//       LoadAcc     in   1        ACC <= source chosen by SelAcc
//       SelAcc      in   2        00 ALU, 10 reg[operand], 11 immediate, 01 reserved
//       SelALU      in   4        ALU function
//       imem_addr   out  PC_W     = PC
//       op          out  4        = IR[7:4]
//       z, c        out  1        flag registers
//       acc         out  DATA_W   = ACC
//       illegal_op  out  1        sticky illegal-opcode flag (DP_ILLEGAL_OP_EN only)
//    Build option: define DP_ILLEGAL_OP_EN to add illegal_op.
module cpu_datapath
   import cpu_datapath_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8
) (
   input  logic              clk,
   input  logic              CLB,
   input  logic [7:0]        imem_data,
   input  logic              LoadIR,
   input  logic              IncPC,
   input  logic              SelPC,
   input  logic              LoadPC,
   input  logic              LoadReg,
   input  logic              LoadAcc,
   input  logic [1:0]        SelAcc,
   input  logic [3:0]        SelALU,
   output logic [PC_W-1:0]   imem_addr,
   output logic [3:0]        op,
   output logic              z,
   output logic              c,
   output logic [DATA_W-1:0] acc
`ifdef DP_ILLEGAL_OP_EN
   ,
   output logic              illegal_op
`endif
);

   logic [PC_W-1:0]   pc_r;
   logic [7:0]        ir_r;
   logic [DATA_W-1:0] acc_r;
   logic              z_r;
   logic              c_r;
   logic [DATA_W-1:0] regs_r [16];

   logic [3:0]        opc_s;
   logic [3:0]        operand_s;
   logic [DATA_W-1:0] b_s;
   logic [DATA_W-1:0] alu_res_s;
   logic              alu_cout_s;
   logic              taken_s;
   logic [PC_W-1:0]   pc_next_s;
   logic [DATA_W-1:0] acc_next_s;
   logic              z_next_s;
   logic              c_next_s;

   assign opc_s     = ir_r[7:4];
   assign operand_s = ir_r[3:0];
   // Register-file read is the pre-edge content: a same-edge LoadReg is not bypassed
   assign b_s       = regs_r[operand_s];

   assign imem_addr = pc_r;
   assign op        = opc_s;
   assign z         = z_r;
   assign c         = c_r;
   assign acc       = acc_r;

   cpu_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a      (acc_r),
      .b      (b_s),
      .fn     (SelALU),
      .cin    (c_r),
      .result (alu_res_s),
      .cout   (alu_cout_s)
   );

   // PC next-state: a taken jump wins over increment
   always_comb begin
      taken_s = LoadPC &
                ((((opc_s == OP_JZRS) || (opc_s == OP_JZIM)) & z_r) |
                 (((opc_s == OP_JCRS) || (opc_s == OP_JCIM)) & c_r));
      pc_next_s = pc_r;
      if (taken_s) begin
         if (SelPC) begin
            pc_next_s = PC_W'(b_s);
         end else begin
            pc_next_s = PC_W'(operand_s);
         end
      end else if (IncPC) begin
         pc_next_s = pc_r + PC_W'(1);   // wraps modulo 2^PC_W
      end else begin
         pc_next_s = pc_r;
      end
   end

   // ACC / flag next-state; the reserved select holds everything
   always_comb begin
      acc_next_s = acc_r;
      z_next_s   = z_r;
      c_next_s   = c_r;
      if (LoadAcc) begin
         case (SelAcc)
            SEL_ACC_ALU: begin
               acc_next_s = alu_res_s;
               c_next_s   = alu_cout_s;
               z_next_s   = (alu_res_s == '0);
            end
            SEL_ACC_REG: begin
               acc_next_s = b_s;
               z_next_s   = (b_s == '0);
            end
            SEL_ACC_IMM: begin
               acc_next_s = DATA_W'(operand_s);
               z_next_s   = (operand_s == 4'd0);
            end
            default: begin
               acc_next_s = acc_r;
               z_next_s   = z_r;
               c_next_s   = c_r;
            end
         endcase
      end else begin
         acc_next_s = acc_r;
         z_next_s   = z_r;
         c_next_s   = c_r;
      end
   end

   // PC, IR, ACC and flag registers
   always_ff @(posedge clk or negedge CLB) begin
      if (!CLB) begin
         pc_r  <= '0;
         ir_r  <= 8'h00;
         acc_r <= '0;
         z_r   <= 1'b0;
         c_r   <= 1'b0;
      end else begin
         pc_r  <= pc_next_s;
         acc_r <= acc_next_s;
         z_r   <= z_next_s;
         c_r   <= c_next_s;
         if (LoadIR) begin
            ir_r <= imem_data;
         end else begin
            ir_r <= ir_r;
         end
      end
   end

   // Register file: write the pre-edge ACC to reg[operand]
   always_ff @(posedge clk or negedge CLB) begin
      if (!CLB) begin
         for (int i = 0; i < 16; i++) begin
            regs_r[i] <= '0;
         end
      end else if (LoadReg) begin
         regs_r[operand_s] <= acc_r;
      end else begin
         regs_r[operand_s] <= regs_r[operand_s];
      end
   end

`ifdef DP_ILLEGAL_OP_EN
   // Sticky illegal-opcode flag, cleared only by reset
   always_ff @(posedge clk or negedge CLB) begin
      if (!CLB) begin
         illegal_op <= 1'b0;
      end else if (LoadIR && is_illegal_op(imem_data[7:4])) begin
         illegal_op <= 1'b1;
      end else begin
         illegal_op <= illegal_op;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath
//    Scoreboarded bench for cpu_datapath: each stimulus cycle pushes the
//    expected post-edge state from an arithmetic reference model; a monitor
//    pops and compares after every rising edge. Directed scenarios cover
//    immediate load, ADD/SUB carries, conditional jumps and PC wrap, then
//    randomized strobes run with a mid-run asynchronous reset.
module tb_cpu_datapath;
   import cpu_datapath_pkg::*;

   logic       clk = 1'b0;
   logic       CLB = 1'b0;
   logic [7:0] imem_data;
   logic       LoadIR = 1'b0, IncPC = 1'b0, SelPC = 1'b0, LoadPC = 1'b0;
   logic       LoadReg = 1'b0, LoadAcc = 1'b0;
   logic [1:0] SelAcc = 2'b00;
   logic [3:0] SelALU = 4'b0000;
   logic [7:0] imem_addr;
   logic [3:0] op;
   logic       z, c;
   logic [7:0] acc;
`ifdef DP_ILLEGAL_OP_EN
   logic       illegal_op;
`endif

   cpu_datapath #(.DATA_W(8), .PC_W(8)) dut (
      .clk(clk), .CLB(CLB), .imem_data(imem_data),
      .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
      .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
      .imem_addr(imem_addr), .op(op), .z(z), .c(c), .acc(acc)
`ifdef DP_ILLEGAL_OP_EN
      , .illegal_op(illegal_op)
`endif
   );

   always #5 clk = ~clk;

   // Instruction ROM, read combinationally at the DUT's address
   logic [7:0] rom [256];
   always_comb imem_data = rom[imem_addr];

   typedef struct {
      int pc; int op; int acc; int z; int c; int ill;
   } exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int m_pc, m_ir, m_acc, m_z, m_c, m_ill;
   int m_rf [16];

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0; m_ill = 0;
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
   endtask

   // One cycle: drive strobes at the falling edge, advance model, queue expectation
   task automatic step(input bit lir, input bit inc, input bit spc, input bit lpc,
                       input bit lreg, input bit lacc, input int sacc, input int salu);
      int opc, opnd, b, instr, npc, nacc, nz, nc, res, co;
      bit taken;
      exp_t e;
      @(negedge clk);
      LoadIR = lir; IncPC = inc; SelPC = spc; LoadPC = lpc;
      LoadReg = lreg; LoadAcc = lacc; SelAcc = 2'(sacc); SelALU = 4'(salu);
      opc = m_ir / 16; opnd = m_ir % 16; b = m_rf[opnd]; instr = int'(rom[m_pc]);
      taken = lpc && ((((opc == 6) || (opc == 7)) && m_z != 0) ||
                      (((opc == 8) || (opc == 10)) && m_c != 0));
      if (taken) npc = spc ? b : opnd;
      else if (inc) npc = (m_pc + 1) % 256;
      else npc = m_pc;
      // ALU from its arithmetic definition
      case (salu)
         1:  begin res = (m_acc + b) % 256; co = (m_acc + b > 255) ? 1 : 0; end
         2:  begin res = (m_acc - b + 256) % 256; co = (m_acc < b) ? 1 : 0; end
         3:  begin res = 255 - (m_acc | b); co = 0; end
         11: begin res = (m_acc * 2) % 256; co = m_acc / 128; end
         12: begin res = m_acc / 2; co = m_acc % 2; end
         default: begin res = m_acc; co = m_c; end
      endcase
      nacc = m_acc; nz = m_z; nc = m_c;
      if (lacc) begin
         if (sacc == 0) begin nacc = res; nc = co; nz = (res == 0); end
         else if (sacc == 2) begin nacc = b; nz = (b == 0); end
         else if (sacc == 3) begin nacc = opnd; nz = (opnd == 0); end
      end
      if (lreg) m_rf[opnd] = m_acc;
      if (lir) begin
         m_ir = instr;
         if ((instr / 16 == 9) || (instr / 16 == 14)) m_ill = 1;
      end
      m_pc = npc; m_acc = nacc; m_z = nz; m_c = nc;
      e.pc = m_pc; e.op = m_ir / 16; e.acc = m_acc; e.z = m_z; e.c = m_c; e.ill = m_ill;
      exp_q.push_back(e);
   endtask

   task automatic ld_ir(input int v);
      rom[m_pc] = 8'(v);
      step(1, 1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic alu(input int fn);
      step(0, 0, 0, 0, 0, 1, 0, fn);
   endtask

   task automatic imm();
      step(0, 0, 0, 0, 0, 1, 3, 0);
   endtask

   task automatic chk_reset_state();
      chk("rst_pc", int'(imem_addr), 0);
      chk("rst_op", int'(op), 0);
      chk("rst_acc", int'(acc), 0);
      chk("rst_z", int'(z), 0);
      chk("rst_c", int'(c), 0);
`ifdef DP_ILLEGAL_OP_EN
      chk("rst_ill", int'(illegal_op), 0);
`endif
   endtask

   // Asynchronous reset asserted mid-cycle, checked before the next edge
   task automatic async_reset();
      @(negedge clk);
      LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; LoadReg = 0; LoadAcc = 0;
      #1 CLB = 1'b0;
      #1 chk_reset_state();
      model_reset();
      #1 CLB = 1'b1;
   endtask

   // Monitor: compare every queued expectation after the rising edge
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("pc", int'(imem_addr), e.pc);
         chk("op", int'(op), e.op);
         chk("acc", int'(acc), e.acc);
         chk("z", int'(z), e.z);
         chk("c", int'(c), e.c);
`ifdef DP_ILLEGAL_OP_EN
         chk("illegal_op", int'(illegal_op), e.ill);
`endif
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
      model_reset();
      #3 chk_reset_state();
      #4 CLB = 1'b1;

      // Immediate load: op=D, PC=1, acc=5
      ld_ir(8'hD5); imm();
      // ACC=0x20, store to r3; ACC=0xF0; ADD r3 -> 0x10 with carry
      ld_ir(8'hD2); imm(); repeat (4) alu(11);
      ld_ir(8'h53); step(0, 0, 0, 0, 1, 0, 0, 0);
      ld_ir(8'hDF); imm(); repeat (4) alu(11);
      ld_ir(8'h13); alu(1);
      // SUB equal -> zero; 1 - 2 -> 0xFF with borrow
      ld_ir(8'h43); step(0, 0, 0, 0, 0, 1, 2, 0);
      ld_ir(8'h23); alu(2);
      ld_ir(8'hD2); imm(); ld_ir(8'h52); step(0, 0, 0, 0, 1, 0, 0, 0);
      ld_ir(8'hD1); imm(); ld_ir(8'h22); alu(2);
      // Reserved select holds ACC and flags
      step(0, 0, 0, 0, 0, 1, 1, 1);
      // JZIM 7 taken, then not taken
      ld_ir(8'hD0); imm(); ld_ir(8'h77); step(0, 0, 0, 1, 0, 0, 0, 0);
      ld_ir(8'hD1); imm(); ld_ir(8'h77); step(0, 0, 0, 1, 0, 0, 0, 0);
      // JCRS r2 = 0x40 with c=1, with simultaneous LoadAcc/LoadReg
      ld_ir(8'hD4); imm(); repeat (4) alu(11);
      ld_ir(8'h52); step(0, 0, 0, 0, 1, 1, 0, 11);
      ld_ir(8'hD8); imm(); repeat (5) alu(11);
      ld_ir(8'h82); step(0, 1, 1, 1, 0, 0, 0, 0);
      // Non-jump op with LoadPC is a plain increment
      ld_ir(8'h10); step(0, 1, 0, 1, 0, 0, 0, 0);
      // PC=0xFF via JCRS r5, then wrap to 0
      ld_ir(8'hD0); imm(); ld_ir(8'h30); alu(3);
      ld_ir(8'h55); step(0, 0, 0, 0, 1, 0, 0, 0);
      alu(11);
      ld_ir(8'h85); step(0, 0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      // Illegal opcode capture, held through NOPs
      ld_ir(8'h93); ld_ir(8'h00); step(0, 1, 0, 0, 0, 0, 0, 0);
      async_reset();

      // Randomized strobes with a reset in the middle
      for (int k = 0; k < 1200; k++) begin
         if (k == 600) async_reset();
         step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 15));
      end
      @(negedge clk);
      LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; LoadReg = 0; LoadAcc = 0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

endmodule
